// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Multiply is radix-2 shift-add on operand magnitudes, divide
// is restoring shift-subtract on magnitudes, and a final FIX cycle applies the
// sign correction before writing HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5    // 2**CNT_W must be >= WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  // Architectural and control state
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;

  // Working registers for the operation in flight
  logic               is_div_q, is_div_d;   // divide (1) or multiply (0)
  logic               b_zero_q, b_zero_d;   // divisor was zero
  logic               neg_q_q,  neg_q_d;    // negate product / quotient in FIX
  logic               neg_r_q,  neg_r_d;    // negate remainder in FIX
  logic [WIDTH-1:0]   dvd_q,    dvd_d;      // raw dividend, returned as HI on divide-by-zero
  logic [WIDTH-1:0]   mag_q,    mag_d;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q,    acc_d;      // {partial hi, shifting lo} accumulator

  // Operand decode at request time
  logic               op_arith;
  logic               op_signed;
  logic               op_is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    op_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    // The most negative value maps onto itself, which read unsigned is its magnitude.
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits and shift the quotient bit in from the right.
  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, mag_q});
    div_diff  = div_shift - {1'b0, mag_q};
    if (div_ge) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix = neg_q_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, datapath and HI/LO update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvd_d    = dvd_q;
    mag_d    = mag_q;
    acc_d    = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_arith) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            is_div_d = op_is_div;
            b_zero_d = (b == '0);
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            dvd_d    = a;
            if (op_is_div) begin
              mag_d = b_mag;
              acc_d = {{WIDTH{1'b0}}, a_mag};
            end else begin
              mag_d = a_mag;
              acc_d = {{WIDTH{1'b0}}, b_mag};
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          if (b_zero_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset clears everything and aborts any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvd_q    <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dvd_q    <= dvd_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit: hand-computed MULT/MULTU/DIV/DIVU
// vectors, MTHI/MTLO, ignored requests while busy, operand capture and
// mid-operation reset. Inputs change and outputs are sampled on the falling edge.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: plain; 1: scramble a/b every cycle; 2: pulse MTLO at cycle 5 of CALC
  task automatic run_op(input string tag, input logic [2:0] op_v,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int mode);
    int k;
    int busy_cnt;
    @(negedge clk);
    op = op_v; a = a_v; b = b_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (mode == 1) begin
        a = $urandom;
        b = $urandom;
      end
      if (mode == 2 && k == 5) begin
        op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1;
      end
      if (mode == 2 && k == 6) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 64'(k), 64'd34);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op_v, a_v, b_v, hi, lo);
  endtask

  initial begin
    int done_cnt;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    $display("[TB] reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
    reset = 1'b0;

    run_op("mult_neg3x5",  3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu_max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div_neg7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_by0",     3'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 0);
    run_op("div_min_m1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("mult_minsq",   3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("div_7_neg2",   3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div_neg5_by0", 3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

    // Reserved opcode: nothing happens
    @(negedge clk);
    op = 3'd6; a = 32'h5555_5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rsvd.busy", 64'(busy), 64'd0);
    check("rsvd.hi", 64'(hi), 64'hFFFF_FFFB);
    check("rsvd.lo", 64'(lo), 64'hFFFF_FFFF);
    $display("[TB] reserved op 6: busy=%0b hi=%h lo=%h", busy, hi, lo);

    // MTHI in IDLE
    op = 3'd4; a = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mthi.hi", 64'(hi), 64'h1234_5678);
    check("mthi.lo", 64'(lo), 64'hFFFF_FFFF);
    check("mthi.busy", 64'(busy), 64'd0);
    check("mthi.done", 64'(done), 64'd0);
    @(negedge clk);
    check("mthi.done_next", 64'(done), 64'd0);
    $display("[TB] mthi: hi=%h lo=%h busy=%0b", hi, lo, busy);

    run_op("divu_7_2_mtlo", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 2);
    run_op("multu_capture", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1);

    // Reset in the middle of a DIV
    @(negedge clk);
    op = 3'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    $display("[TB] reset mid-DIV: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst.no_done", 64'(done_cnt), 64'd0);
    check("midrst.hi_after", 64'(hi), 64'd0);
    check("midrst.lo_after", 64'(lo), 64'd0);

    run_op("mult_2x3", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
